// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter (LSB first) with a small byte FIFO in
// front of the serialiser so the host can queue several frames at once.
// All outputs are registered; the line idles high.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT    = 87,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                       i_Clock,
    input  logic                       i_Reset,
    input  logic                       i_Tx_DV,
    input  logic [7:0]                 i_Tx_Byte,
    output logic                       o_Tx_Ready,
    output logic                       o_Tx_Serial,
    output logic                       o_Tx_Active,
    output logic                       o_Tx_Done,
    output logic [FIFO_DEPTH_LOG2:0]   o_Fifo_Count
);

    localparam int                      DEPTH      = 1 << FIFO_DEPTH_LOG2;
    localparam logic [15:0]             TIMER_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0]             TIMER_DONE = 16'(CLKS_PER_BIT - 2);
    localparam logic [FIFO_DEPTH_LOG2:0] COUNT_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [FIFO_DEPTH_LOG2:0] COUNT_ZERO = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // FIFO storage and pointers
    logic [7:0]                 fifo_mem_q [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH_LOG2:0]   count_q,  count_d;
    logic                       ready_q,  ready_d;

    // Serialiser state
    state_t                     state_q,  state_d;
    logic [15:0]                timer_q,  timer_d;
    logic [2:0]                 index_q,  index_d;
    logic [7:0]                 shift_q,  shift_d;
    logic                       serial_q, serial_d;
    logic                       active_q, active_d;
    logic                       done_q,   done_d;

    logic                       push_s;
    logic                       pop_s;

    // Push only when not full (ready is derived from the registered count);
    // the serialiser pops only from IDLE with data waiting.
    assign push_s = i_Tx_DV & ready_q;
    assign pop_s  = (state_q == ST_IDLE) && (count_q != COUNT_ZERO);

    // FIFO pointer / occupancy next-state; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ready_d = (count_d != COUNT_FULL);
    end

    // Frame sequencing; outputs are computed for the state being entered so
    // the registered line/active/done line up with the state itself
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        index_d  = index_q;
        shift_d  = shift_q;
        serial_d = serial_q;
        active_d = active_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    shift_d  = fifo_mem_q[rd_ptr_q];
                    timer_d  = 16'd0;
                    state_d  = ST_START;
                    serial_d = 1'b0;
                    active_d = 1'b1;
                end else begin
                    serial_d = 1'b1;
                    active_d = 1'b0;
                end
            end
            ST_START: begin
                if (timer_q == TIMER_LAST) begin
                    timer_d  = 16'd0;
                    index_d  = 3'd0;
                    state_d  = ST_DATA;
                    serial_d = shift_q[0];
                end else begin
                    timer_d  = timer_q + 16'd1;
                    serial_d = 1'b0;
                end
            end
            ST_DATA: begin
                if (timer_q == TIMER_LAST) begin
                    timer_d = 16'd0;
                    if (index_q == 3'd7) begin
                        index_d  = 3'd0;
                        state_d  = ST_STOP;
                        serial_d = 1'b1;
                    end else begin
                        index_d  = index_q + 3'd1;
                        serial_d = shift_q[index_q + 3'd1];
                    end
                end else begin
                    timer_d  = timer_q + 16'd1;
                    serial_d = shift_q[index_q];
                end
            end
            ST_STOP: begin
                if (timer_q == TIMER_LAST) begin
                    timer_d  = 16'd0;
                    state_d  = ST_IDLE;
                    serial_d = 1'b1;
                    active_d = 1'b0;
                end else begin
                    timer_d  = timer_q + 16'd1;
                    serial_d = 1'b1;
                    // Raise Done so it is visible during the final stop clock
                    if (timer_q == TIMER_DONE) begin
                        done_d = 1'b1;
                    end else begin
                        done_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                timer_d  = 16'd0;
                index_d  = 3'd0;
                serial_d = 1'b1;
                active_d = 1'b0;
            end
        endcase
    end

    // FIFO storage write; contents are cleared on reset so queued bytes vanish
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem_q[i] <= 8'd0;
            end
        end else if (push_s) begin
            fifo_mem_q[wr_ptr_q] <= i_Tx_Byte;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
            state_q  <= ST_IDLE;
            timer_q  <= 16'd0;
            index_q  <= 3'd0;
            shift_q  <= 8'd0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            state_q  <= state_d;
            timer_q  <= timer_d;
            index_q  <= index_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign o_Tx_Ready   = ready_q;
    assign o_Tx_Serial  = serial_q;
    assign o_Tx_Active  = active_q;
    assign o_Tx_Done    = done_q;
    assign o_Fifo_Count = count_q;

endmodule
